// File: rtl/dual_port_ram_pkg.sv
// Shared types for the byte-enabled dual-port RAM: read-during-write modes, FSM states, counter width.
// No logic; latency and backpressure live in the modules that import it.
package dual_port_ram_pkg;

  typedef enum logic [1:0] {
    WRITE_FIRST = 2'd0,
    READ_FIRST  = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } fsm_state_e;

  localparam int COLL_CNT_W = 16;

endpackage

// File: rtl/dual_port_ram_port_pipe.sv
// One port's response path: picks old/new word by RDW mode, delays it READ_LATENCY (1 or 2) cycles.
// No backpressure: a new request may enter every cycle; q holds between valid pulses.
module dual_port_ram_port_pipe
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [DATA_WIDTH-1:0] old_dat,
  input  logic [DATA_WIDTH-1:0] new_dat,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);

  logic                  resp_vld;
  logic [DATA_WIDTH-1:0] resp_dat;

  // A NO_CHANGE write produces no response at all, so it never disturbs q.
  assign resp_vld = req_vld && !(req_wr && (RDW_MODE == int'(NO_CHANGE)));
  assign resp_dat = (req_wr && (RDW_MODE == int'(WRITE_FIRST))) ? new_dat : old_dat;

  if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_mode
    $error("RDW_MODE must be 0, 1 or 2");
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clock) begin
      if (reset) begin
        q       <= '0;
        q_valid <= 1'b0;
      end else begin
        q_valid <= resp_vld;
        if (resp_vld) q <= resp_dat;
      end
    end
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;
    always_ff @(posedge clock) begin
      if (reset) begin
        s1_vld  <= 1'b0;
        s1_dat  <= '0;
        q       <= '0;
        q_valid <= 1'b0;
      end else begin
        s1_vld  <= resp_vld;
        s1_dat  <= resp_dat;
        q_valid <= s1_vld;
        if (s1_vld) q <= s1_dat;
      end
    end
  end else begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end

endmodule

// File: rtl/dual_port_ram_bw.sv
// Byte-enabled true dual-port RAM with collision counting; DUAL_PORT_RAM_INIT_CLEAR_EN adds a post-reset zeroing sweep.
// Responses READ_LATENCY cycles after a request; no backpressure, both ports accept every READY cycle.
module dual_port_ram_bw
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             init_busy,
  input  logic                             en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            data_a,
  output logic [DATA_WIDTH-1:0]            q_a,
  output logic                             q_valid_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            data_b,
  output logic [DATA_WIDTH-1:0]            q_b,
  output logic                             q_valid_b,
  output logic                             collision,
  output logic [COLL_CNT_W-1:0]            collision_count
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] S_READY = READY;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] base,
                                                        input logic [DATA_WIDTH-1:0] wdat,
                                                        input logic [NB-1:0]         we);
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int k = 0; k < NB; k++) begin
      if (we[k]) r[k*BYTE_WIDTH +: BYTE_WIDTH] = wdat[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic                  acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;
  logic                  coll_now, coll_pre;
  logic [1:0]            coll_sr;

  assign acc_a     = en_a && !reset && (state == S_READY);
  assign acc_b     = en_b && !reset && (state == S_READY);
  assign wr_a      = |we_a;
  assign wr_b      = |we_b;
  assign same_addr = (addr_a == addr_b);
  assign old_a     = mem[addr_a];
  assign old_b     = mem[addr_b];

  // Both ports see the fully resolved word: B's lanes first, then A's on top so A wins shared lanes.
  assign new_a = merge_lanes(merge_lanes(old_a, data_b, (same_addr && acc_b) ? we_b : '0), data_a, we_a);
  assign new_b = merge_lanes(merge_lanes(old_b, data_b, we_b), data_a, (same_addr && acc_a) ? we_a : '0);

`ifdef DUAL_PORT_RAM_INIT_CLEAR_EN
  localparam logic [0:0] S_INIT = INIT;
  logic [ADDR_WIDTH-1:0] sweep_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_INIT;
      sweep_addr <= '0;
    end else if (state == S_INIT) begin
      sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
      if (&sweep_addr) state <= S_READY;
    end
  end

  assign init_busy = (state == S_INIT);
`else
  always_ff @(posedge clock) begin
    if (reset) state <= S_READY;
  end

  assign init_busy = 1'b0;
`endif

  always_ff @(posedge clock) begin
`ifdef DUAL_PORT_RAM_INIT_CLEAR_EN
    if (!reset && state == S_INIT) mem[sweep_addr] <= '0;
`endif
    if (acc_b && wr_b) mem[addr_b] <= new_b;
    if (acc_a && wr_a) mem[addr_a] <= new_a;
  end

  dual_port_ram_port_pipe #(
    .DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY), .RDW_MODE(RDW_MODE)
  ) u_pipe_a (
    .clock(clock), .reset(reset), .req_vld(acc_a), .req_wr(wr_a),
    .old_dat(old_a), .new_dat(new_a), .q(q_a), .q_valid(q_valid_a)
  );

  dual_port_ram_port_pipe #(
    .DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY), .RDW_MODE(RDW_MODE)
  ) u_pipe_b (
    .clock(clock), .reset(reset), .req_vld(acc_b), .req_wr(wr_b),
    .old_dat(old_b), .new_dat(new_b), .q(q_b), .q_valid(q_valid_b)
  );

  // Collision pulse and count share the responses' timing; count moves on the edge the pulse rises.
  assign coll_now  = acc_a && acc_b && same_addr && (wr_a || wr_b);
  assign coll_pre  = (READ_LATENCY == 1) ? coll_now : coll_sr[0];
  assign collision = (READ_LATENCY == 1) ? coll_sr[0] : coll_sr[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      coll_sr         <= '0;
      collision_count <= '0;
    end else begin
      coll_sr <= {coll_sr[0], coll_now};
      if (coll_pre && (collision_count != '1)) collision_count <= collision_count + COLL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_port_ram_bw.sv
// Drives four RAM variants (WF/RF/NC at latency 1, WF at latency 2) with one stimulus stream.
// Expected outputs come from a word-array model with responses scheduled by cycle number.
module tb_dual_port_ram_bw;

`ifdef DUAL_PORT_RAM_INIT_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif
  localparam int NI = 4;
  localparam int RL_T   [NI] = '{1, 1, 1, 2};
  localparam int MODE_T [NI] = '{0, 1, 2, 0};

  logic        clock = 1'b0;
  logic        reset;
  logic        en_a, en_b;
  logic [1:0]  we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;

  logic        init_busy_o [NI];
  logic [15:0] q_a_o [NI], q_b_o [NI], cnt_o [NI];
  logic        qv_a_o [NI], qv_b_o [NI], coll_o [NI];

  always #5 clock = ~clock;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    dual_port_ram_bw #(
      .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
      .READ_LATENCY(RL_T[i]), .RDW_MODE(MODE_T[i])
    ) u_dut (
      .clock(clock), .reset(reset), .init_busy(init_busy_o[i]),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
      .q_a(q_a_o[i]), .q_valid_a(qv_a_o[i]),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
      .q_b(q_b_o[i]), .q_valid_b(qv_b_o[i]),
      .collision(coll_o[i]), .collision_count(cnt_o[i])
    );
  end

  // Reference model state
  logic [15:0] mem_m [16];
  bit          m_ready;
  int          m_sweep;
  int          cyc;
  bit          pv [NI][2][4];
  logic [15:0] pd [NI][2][4];
  bit          pc [NI][4];
  logic [15:0] hq [NI][2];
  int          hcnt [NI];
  int          checks, failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] apply_we(input logic [15:0] w, input logic [15:0] d, input logic [1:0] we);
    logic [15:0] r;
    r = w;
    if (we[0]) r[7:0]  = d[7:0];
    if (we[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic check_outputs();
    int s;
    s = cyc % 4;
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pv[i][p][s]) hq[i][p] = pd[i][p][s];
      end
      if (pc[i][s] && hcnt[i] < 65535) hcnt[i]++;
      chk($sformatf("i%0d_qv_a", i), 32'(qv_a_o[i]), 32'(pv[i][0][s]));
      chk($sformatf("i%0d_qv_b", i), 32'(qv_b_o[i]), 32'(pv[i][1][s]));
      chk($sformatf("i%0d_q_a", i), 32'(q_a_o[i]), 32'(hq[i][0]));
      chk($sformatf("i%0d_q_b", i), 32'(q_b_o[i]), 32'(hq[i][1]));
      chk($sformatf("i%0d_coll", i), 32'(coll_o[i]), 32'(pc[i][s]));
      chk($sformatf("i%0d_cnt", i), 32'(cnt_o[i]), 32'(hcnt[i]));
      chk($sformatf("i%0d_busy", i), 32'(init_busy_o[i]), 32'(CLEAR && !m_ready));
      pv[i][0][s] = 1'b0;
      pv[i][1][s] = 1'b0;
      pc[i][s]    = 1'b0;
    end
  endtask

  // Advance one clock: account for the inputs presented now, then check what the edge produced.
  task automatic tick();
    logic [15:0] nm [16];
    bit acc_a, acc_b, wa, wb, coll;
    int t;
    nm = mem_m;
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        for (int s = 0; s < 4; s++) begin
          pv[i][0][s] = 1'b0;
          pv[i][1][s] = 1'b0;
          pc[i][s]    = 1'b0;
        end
        hq[i][0] = '0;
        hq[i][1] = '0;
        hcnt[i]  = 0;
      end
      m_ready = !CLEAR;
      m_sweep = 0;
    end else begin
      acc_a = en_a && m_ready;
      acc_b = en_b && m_ready;
      wa    = acc_a && (we_a != 2'b00);
      wb    = acc_b && (we_b != 2'b00);
      if (wb) nm[addr_b] = apply_we(nm[addr_b], data_b, we_b);
      if (wa) nm[addr_a] = apply_we(nm[addr_a], data_a, we_a);
      coll = acc_a && acc_b && (addr_a == addr_b) && (wa || wb);
      for (int i = 0; i < NI; i++) begin
        t = (cyc + RL_T[i]) % 4;
        if (acc_a && !(wa && MODE_T[i] == 2)) begin
          pv[i][0][t] = 1'b1;
          pd[i][0][t] = (wa && MODE_T[i] == 0) ? nm[addr_a] : mem_m[addr_a];
        end
        if (acc_b && !(wb && MODE_T[i] == 2)) begin
          pv[i][1][t] = 1'b1;
          pd[i][1][t] = (wb && MODE_T[i] == 0) ? nm[addr_b] : mem_m[addr_b];
        end
        pc[i][t] = coll;
      end
      if (!m_ready) begin
        nm[m_sweep] = '0;
        m_sweep++;
        if (m_sweep == 16) m_ready = 1'b1;
      end
    end
    mem_m = nm;
    @(posedge clock);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 2'b00; addr_a = '0; data_a = '0;
    en_b = 1'b0; we_b = 2'b00; addr_b = '0; data_b = '0;
  endtask

  task automatic drive_a(input logic [1:0] we, input logic [3:0] a, input logic [15:0] d);
    en_a = 1'b1; we_a = we; addr_a = a; data_a = d;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; m_ready = 1'b0; m_sweep = 0;
    for (int k = 0; k < 16; k++) mem_m[k] = '0;
    for (int i = 0; i < NI; i++) begin
      hq[i][0] = '0; hq[i][1] = '0; hcnt[i] = 0;
    end

    // Reset, then measure how long init_busy stays up.
    reset = 1'b1;
    idle();
    repeat (3) tick();
    reset = 1'b0;
    n = int'(init_busy_o[0]);
    repeat (30) begin
      tick();
      n += int'(init_busy_o[0]);
    end
    chk("init_busy_len", 32'(n), CLEAR ? 32'd16 : 32'd0);

    // Without the sweep the array starts undefined, so zero it explicitly.
    if (!CLEAR) begin
      for (int a = 0; a < 16; a++) begin
        drive_a(2'b11, 4'(a), 16'h0000);
        tick();
      end
      idle();
      repeat (2) tick();
    end

    // Every address reads back as zero on both ports.
    for (int a = 0; a < 16; a++) begin
      drive_a(2'b00, 4'(a), 16'h0);
      en_b = 1'b1; we_b = 2'b00; addr_b = 4'(15 - a);
      tick();
      if (a == 0) begin
        chk("rd0_valid", 32'(qv_a_o[0]), 32'd1);
        chk("rd0_data", 32'(q_a_o[0]), 32'h0);
      end
    end
    idle();
    repeat (2) tick();

    // Partial-word update.
    drive_a(2'b11, 4'd3, 16'hABCD); tick();
    drive_a(2'b01, 4'd3, 16'h1234); tick();
    drive_a(2'b00, 4'd3, 16'h0000); tick();
    chk("merge_read", 32'(q_a_o[0]), 32'hAB34);

    // Read-during-write on one port in each mode.
    drive_a(2'b11, 4'd4, 16'hAAAA); tick();
    drive_a(2'b11, 4'd4, 16'h5555); tick();
    chk("rdw_write_first", 32'(q_a_o[0]), 32'h5555);
    chk("rdw_read_first", 32'(q_a_o[1]), 32'hAAAA);
    chk("rdw_no_change_vld", 32'(qv_a_o[2]), 32'd0);
    chk("rdw_no_change_q", 32'(q_a_o[2]), 32'hAB34);
    idle();
    repeat (2) tick();

    // Write/write collision: A wins.
    drive_a(2'b11, 4'd7, 16'h1111);
    en_b = 1'b1; we_b = 2'b11; addr_b = 4'd7; data_b = 16'h2222;
    tick();
    chk("ww_coll_pulse", 32'(coll_o[0]), 32'd1);
    chk("ww_coll_count", 32'(cnt_o[0]), 32'd1);
    idle();
    drive_a(2'b00, 4'd7, 16'h0);
    tick();
    chk("ww_winner", 32'(q_a_o[0]), 32'h1111);
    idle();
    repeat (2) tick();

    // Latency-2 reader streaming over a write to the same word.
    drive_a(2'b11, 4'd5, 16'h0F0F); tick();
    idle();
    en_b = 1'b1; we_b = 2'b00; addr_b = 4'd5;
    tick();
    drive_a(2'b11, 4'd5, 16'hBEEF);
    tick();
    en_a = 1'b0;
    tick();
    chk("rl2_coll_q_b", 32'(q_b_o[3]), 32'h0F0F);
    chk("rl2_coll_pulse", 32'(coll_o[3]), 32'd1);
    chk("rl2_coll_count", 32'(cnt_o[3]), 32'd2);
    tick();
    chk("rl2_after_write", 32'(q_b_o[3]), 32'hBEEF);
    idle();
    repeat (3) tick();

    // Reset while a latency-2 read is in flight drops its response.
    drive_a(2'b00, 4'd7, 16'h0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    chk("rst_drop_valid", 32'(qv_a_o[3]), 32'd0);
    reset = 1'b0;
    if (CLEAR) begin
      for (int k = 0; k < 20 && m_sweep != 9; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = int'(init_busy_o[0]);
      repeat (30) begin
        tick();
        n += int'(init_busy_o[0]);
      end
      chk("restart_busy_len", 32'(n), 32'd16);
    end else begin
      repeat (3) tick();
    end

    // Random traffic on a few addresses to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      en_a   = ($urandom_range(0, 3) != 0);
      we_a   = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
      addr_a = 4'($urandom_range(0, 3));
      data_a = 16'($urandom);
      en_b   = ($urandom_range(0, 3) != 0);
      we_b   = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
      addr_b = 4'($urandom_range(0, 3));
      data_b = 16'($urandom);
      reset  = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
